// File: rtl/fdd_flux_pkg.sv
// fdd_flux_pkg: RLE code values, prescale limits and the interval-to-code helper for fdd_flux_capture
package fdd_flux_pkg;
   localparam logic [7:0] CODE_OVR = 8'h00;
   localparam logic [7:0] CODE_IDX = 8'h01;
   localparam logic [7:0] CODE_MIN = 8'h02;
   localparam int SHIFT_MIN = 0;
   localparam int SHIFT_MAX = 4;
   typedef logic [7:0] code_t;
   function automatic code_t rle_code(input logic ovr, input code_t c);
      return ovr ? CODE_OVR : (c < CODE_MIN) ? CODE_MIN : c;
   endfunction
endpackage

// File: rtl/fdd_flux_fifo.sv
// fdd_flux_fifo: first-word-fall-through byte FIFO with synchronous flush and registered level
module fdd_flux_fifo #(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        push,
   input  logic [7:0]  din,
   input  logic        pop,
   output logic [7:0]  dout,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level
);
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wr_ptr] <= din;
endmodule

// File: rtl/fdd_flux_capture.sv
// fdd_flux_capture: FDD flux-interval RLE capture into a FWFT FIFO for DMA; FDD_IDX_MARK_EN adds index marker codes
module fdd_flux_capture
   import fdd_flux_pkg::*;
#(
   parameter int SHIFT = 1,
   parameter int DEPTH = 16,
   parameter int DCNT_W = 19
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     run,
   input  logic                     rdat_n,
   input  logic                     idx_n,
   input  logic                     req,
   output logic                     stb,
   output logic [7:0]               data,
   output logic                     stop,
   input  logic                     cnt_latch,
   output logic [DCNT_W-1:0]        data_cnt_l,
   output logic                     ovf,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int SH = SHIFT < SHIFT_MIN ? SHIFT_MIN : SHIFT > SHIFT_MAX ? SHIFT_MAX : SHIFT;
   localparam int CW = 8 + SH + 1;
   logic [2:0] rdat_s;
   logic run_r, flux, ovr, start, flush, flux_push, push, full, empty;
   logic [CW-1:0] cnt, c;
   logic [7:0] code, din;
   logic [DCNT_W-1:0] data_cnt;
   assign flux = rdat_s[1] & ~rdat_s[2];
   assign c = cnt >> SH;
   assign ovr = &cnt || |c[CW-1:8];
   assign code = rle_code(ovr, c[7:0]);
   assign start = run & ~run_r;
   assign stop = run_r & ~run;
   assign flush = start | stop;
   assign flux_push = flux & run & run_r;
   assign stb = req & run & ~empty;
`ifdef FDD_IDX_MARK_EN
   logic [2:0] idx_s;
   logic idx_ev, idx_pend, idx_push;
   assign idx_ev = idx_s[2] & ~idx_s[1];
   assign idx_push = idx_pend & run & run_r & ~flux_push;
   assign push = flux_push | idx_push;
   assign din = flux_push ? code : CODE_IDX;
   // a marker only waits behind a flux push; repeat index events collapse into one pending marker
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         idx_s <= '1;
         idx_pend <= 1'b0;
      end else begin
         idx_s <= {idx_s[1:0], idx_n};
         idx_pend <= (start || !run) ? 1'b0 : idx_ev ? 1'b1 : idx_push ? 1'b0 : idx_pend;
      end
`else
   logic unused_idx;
   assign unused_idx = idx_n;
   assign push = flux_push;
   assign din = code;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rdat_s <= '1;
         run_r <= 1'b0;
         cnt <= '1;
         ovf <= 1'b0;
         data_cnt <= '0;
         data_cnt_l <= '0;
      end else begin
         rdat_s <= {rdat_s[1:0], rdat_n};
         run_r <= run;
         cnt <= flux ? CW'(1) : &cnt ? cnt : cnt + CW'(1);
         ovf <= start ? 1'b0 : (push && full && !stb) ? 1'b1 : ovf;
         data_cnt <= start ? '0 : stb ? data_cnt + DCNT_W'(1) : data_cnt;
         if (cnt_latch) data_cnt_l <= data_cnt;
      end
   fdd_flux_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .push(push),
      .din(din),
      .pop(stb),
      .dout(data),
      .full(full),
      .empty(empty),
      .level(level)
   );
endmodule

// File: doc/fdd_flux_capture.md
Name: fdd_flux_capture

Overview:
- Parametrised successor to the FDD flux ripper.
- Measures the interval between read-data pulses from the floppy drive and scales it by a configurable prescale shift.
- Encodes each interval as an 8-bit RLE code, including reserved marker codes.
- Buffers codes in an internal FIFO so DMA latency no longer drops flux samples. It sits between the FDD read-data pin and the DMA source mux.

Parameters:
- SHIFT, 1, interval prescale: code = interval_clocks >> SHIFT (0..4).
- DEPTH, 16, FIFO depth in bytes; power of two, 4..256.
- DCNT_W, 19, width of the transferred-byte counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  capture enable; high = session active
- rdat_n  in  1  raw FDD read data, asynchronous
- idx_n  in  1  raw FDD index pulse, asynchronous, active low
- req  in  1  DMA request (consumer ready)
- stb  out  1  DMA strobe; byte on data is taken this cycle
- data  out  8  FIFO head byte
- stop  out  1  one-cycle pulse at session end
- cnt_latch  in  1  latch transferred-byte count
- data_cnt_l  out  DCNT_W  latched transferred-byte count
- ovf  out  1  sticky FIFO overflow flag
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst_n low, async): all FIFO pointers = 0, level = 0, data = 0, ovf = 0, stop = 0, data_cnt_l = 0, interval counter saturated, index pending = 0, run_r = 0. stb = 0 because FIFO is empty.
- Input sync: rdat_n and idx_n each pass two sync flops plus one history flop.
  - Flux event: synced rdat_n goes 0->1.
  - Index event: synced idx_n goes 1->0.
  - Event latency: 3 clk from pin.
- Interval counter, width 8+SHIFT+1:
  - Loads 1 on a flux event; otherwise increments; saturates at all-ones and holds.
  - Counter runs regardless of run.
- Code on a flux event, computed from the counter value before reload, c = cnt >> SHIFT:
  - c > 255 or counter saturated -> 0x00 (overrun).
  - c < 2 -> 0x02 (clamped).
  - otherwise -> c[7:0].
- Push: a code is pushed only when run = 1 and run_r = 1, i.e. not on the start cycle.
- Session start, run 0->1:
  - FIFO flushed, ovf cleared, data_cnt cleared, index pending cleared.
  - First flux event after start emits the overrun code if the counter is still saturated.
- Session end, run 1->0:
  - stop = 1 for exactly that cycle.
  - FIFO flushed; residual data is discarded.
  - While run = 0, stb = 0.
- FIFO: first-word-fall-through.
  - data shows the head byte whenever level > 0.
  - stb = req && run && (level != 0), combinational; pop on stb.
  - data_cnt increments on stb.
- Simultaneous push and pop:
  - When full: both occur, level unchanged, no overflow.
  - When empty: stb is low that cycle; the push lands and becomes visible next cycle.
- Overflow: push while full and no pop -> byte dropped, ovf = 1 until the next session start.
- cnt_latch: data_cnt_l <= data_cnt on any cycle with cnt_latch = 1. If stb occurs in the same cycle, the pre-increment value is latched.
- level: registered; updates the cycle after a push or pop.

Optional Feature:
- FDD_IDX_MARK_EN defined:
  - Each index event during an active session sets index pending.
  - Pending pushes 0x01 on the first cycle with no flux push, then clears.
  - Flux has priority in the same cycle.
  - A second index event while pending is absorbed.
  - The interval counter is not affected.
- Undefined: idx_n is unused, no marker logic is built, and code 0x01 is never produced.

Decomposition:
- Package fdd_flux_pkg: CODE_OVR = 8'h00, CODE_IDX = 8'h01, CODE_MIN = 8'h02, SHIFT legal range constants.
- Sub-module fdd_flux_fifo: synchronous FWFT FIFO, parameter DEPTH, 8-bit data, ports push/pop/flush/full/empty/level.
- The capture front-end stays in the top level.

Test Plan:
- SHIFT=1, run=1, req=1, flux events 100 clk apart -> each stb carries 0x32. After 10 events, cnt_latch gives data_cnt_l = 10.
- Flux events 600 clk apart (SHIFT=1) -> 0x00. Events 3 clk apart -> 0x02.
- req=0, 20 events, DEPTH=16 -> level = 16, ovf = 1. Raise req -> 16 stb pulses, then stb low, and ovf stays 1 until run toggles.
- Full FIFO with req=1 and a push and pop in the same cycle -> level stays 16, ovf stays 0.
- run 1->0 with 5 bytes queued -> stop high 1 cycle, level 0 next cycle, stb 0. Assert rst_n low mid-session -> all outputs at reset values immediately.
- FDD_IDX_MARK_EN: index falling edge coincident with a flux event -> flux code then 0x01 on consecutive FIFO entries. Without the macro, no 0x01 appears.
